// File: rtl/baud_tick_gen_pkg.sv
// Shared baud-rate divisor constants for the board clock, and the divisor clamp helper.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
//
// The B* constants are the divisors for the 12 MHz board clock, rounded to nearest.
// Any block that needs a fixed baud rate picks its divisor from here.
package baud_tick_gen_pkg;

    localparam int unsigned SYS_CLK_HZ = 12_000_000;

    // Smallest divisor that still produces a distinct tick every period.
    localparam int unsigned DIV_MIN = 2;

    // Rounded divisor for a given baud rate at SYS_CLK_HZ.
    function automatic int unsigned baud_div(input int unsigned baud);
        return (SYS_CLK_HZ + baud / 2) / baud;
    endfunction

    localparam int unsigned B115200 = baud_div(115200);
    localparam int unsigned B57600  = baud_div(57600);
    localparam int unsigned B38400  = baud_div(38400);
    localparam int unsigned B19200  = baud_div(19200);
    localparam int unsigned B9600   = baud_div(9600);
    localparam int unsigned B4800   = baud_div(4800);
    localparam int unsigned B2400   = baud_div(2400);
    localparam int unsigned B1200   = baud_div(1200);

endpackage : baud_tick_gen_pkg

// File: rtl/baud_tick_gen.sv
// Runtime-programmable baud tick / square-clock generator with shadowed divisor and re-phase.
// Latency: tick and clk_out are registered; first tick is high after edge D of enabled counting.
// Backpressure: none; free-running, clk_ena low holds the counter cleared and outputs low.
//
// Ports:
//   clk, rst        system clock (rising edge) and asynchronous active-high reset
//   clk_ena         count enable; low clears the counter and forces outputs low
//   mode            0 = clk_out mirrors tick, 1 = clk_out is a square wave of period D
//   restart         re-phase counter to mid-period (next tick D>>1 edges later)
//   div_load/div_in strobe capturing a new divisor into the shadow register (0/1 clamp to 2)
//   tick            one-cycle pulse every D cycles
//   clk_out         tick (mode 0) or square wave high floor(D/2), low ceil(D/2) (mode 1)
//   div_cur         divisor currently governing the period
module baud_tick_gen
    import baud_tick_gen_pkg::*;
#(
    parameter int N = 16,
    parameter int M = B115200
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_ena,
    input  logic         mode,
    input  logic         restart,
    input  logic         div_load,
    input  logic [N-1:0] div_in,
    output logic         tick,
    output logic         clk_out,
    output logic [N-1:0] div_cur
);

    localparam logic [N-1:0] DIV_RST = N'(M);
    localparam logic [N-1:0] DIV_LO  = N'(DIV_MIN);
    localparam logic [N-1:0] ONE     = N'(1);

    logic [N-1:0] cnt_q,    cnt_d;
    logic [N-1:0] div_q,    div_d;
    logic [N-1:0] div_sh_q, div_sh_d;
    logic         pend_q,   pend_d;
    logic         tick_q,   tick_d;
    logic         clk_out_q, clk_out_d;

    logic [N-1:0] div_in_clamped;
    logic         wrap;
    logic         apply;

    always_comb begin
        div_in_clamped = (div_in < DIV_LO) ? DIV_LO : div_in;

        // D >= 2 always, so D-1 never underflows at N bits.
        wrap = (cnt_q == (div_q - ONE));

        // A shadowed divisor only takes over at a period boundary: a real wrap
        // (restart overrides the wrap, so it is not a boundary) or while disabled.
        apply = pend_q && (!clk_ena || (!restart && wrap));

        div_d = apply ? div_sh_q : div_q;

        // A load on the same edge as an apply lands in the shadow after the old
        // shadow has been consumed, so it stays pending for the next boundary.
        div_sh_d = div_load ? div_in_clamped : div_sh_q;
        if (div_load) begin
            pend_d = 1'b1;
        end else if (apply) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end

        cnt_d  = cnt_q + ONE;
        tick_d = 1'b0;
        if (!clk_ena) begin
            cnt_d = '0;
        end else if (restart) begin
            // Landing at ceil(D/2) leaves floor(D/2) edges until the next wrap,
            // which centres a UART receiver on the bit.
            cnt_d = div_q - (div_q >> 1);
        end else if (wrap) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end

        // Square wave uses the divisor that will be in effect after this edge,
        // so the first period after a divisor change already has the new duty.
        if (!clk_ena) begin
            clk_out_d = 1'b0;
        end else if (mode) begin
            clk_out_d = (cnt_d < (div_d >> 1));
        end else begin
            clk_out_d = tick_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            div_q     <= DIV_RST;
            div_sh_q  <= DIV_RST;
            pend_q    <= 1'b0;
            tick_q    <= 1'b0;
            clk_out_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            div_sh_q  <= div_sh_d;
            pend_q    <= pend_d;
            tick_q    <= tick_d;
            clk_out_q <= clk_out_d;
        end
    end

    assign tick    = tick_q;
    assign clk_out = clk_out_q;
    assign div_cur = div_q;

endmodule : baud_tick_gen

// File: tb/tb_baud_tick_gen.sv
// Scoreboard bench for baud_tick_gen: stimulus pushes expected tick cycles and
// expected output samples keyed by cycle; a negedge monitor pops and compares.
module tb_baud_tick_gen;

    localparam int N     = 16;
    localparam int M_EXP = 104;   // 12 MHz / 115200, rounded

    localparam int K_TICK = 0;
    localparam int K_CLKO = 1;
    localparam int K_DIV  = 2;

    typedef struct {
        int cyc;
        int kind;
        int val;
    } samp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         clk_ena;
    logic         mode;
    logic         restart;
    logic         div_load;
    logic [N-1:0] div_in;
    logic         tick;
    logic         clk_out;
    logic [N-1:0] div_cur;

    int    cyc = 0;
    int    n_pass = 0;
    int    n_total = 0;
    int    tick_q[$];
    samp_t samp_q[$];

    baud_tick_gen #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .clk_ena  (clk_ena),
        .mode     (mode),
        .restart  (restart),
        .div_load (div_load),
        .div_in   (div_in),
        .tick     (tick),
        .clk_out  (clk_out),
        .div_cur  (div_cur)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    endtask

    // Monitor: outputs are sampled mid-cycle, after edge number `cyc`.
    always @(negedge clk) begin
        bit exp_tick;
        int got;
        exp_tick = (tick_q.size() > 0) && (tick_q[0] == cyc);
        if (exp_tick || tick) begin
            check($sformatf("tick@%0d", cyc), int'(tick), int'(exp_tick));
            if (exp_tick) void'(tick_q.pop_front());
        end
        for (int i = samp_q.size() - 1; i >= 0; i--) begin
            if (samp_q[i].cyc <= cyc) begin
                case (samp_q[i].kind)
                    K_TICK:  got = int'(tick);
                    K_CLKO:  got = int'(clk_out);
                    default: got = int'(div_cur);
                endcase
                if (samp_q[i].cyc < cyc)
                    check($sformatf("late_sample_k%0d", samp_q[i].kind), cyc, samp_q[i].cyc);
                else
                    check($sformatf("samp_k%0d@%0d", samp_q[i].kind, cyc), got, samp_q[i].val);
                samp_q.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) step();
    endtask

    task automatic samp(input int c, input int kind, input int val);
        samp_t s;
        s.cyc = c; s.kind = kind; s.val = val;
        samp_q.push_back(s);
    endtask

    task automatic exp_tick(input int c);
        tick_q.push_back(c);
    endtask

    // Square-wave tables, k = edges since enable/apply.
    int sq7[1:14] = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1};
    int sq8[0:15] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};

    initial begin
        int c0, c1, c2, c3, c4, c5, c6;
        rst = 1'b1; clk_ena = 1'b0; mode = 1'b0; restart = 1'b0;
        div_load = 1'b0; div_in = '0;

        // Reset defaults
        step(); step();
        samp(cyc, K_TICK, 0); samp(cyc, K_CLKO, 0); samp(cyc, K_DIV, M_EXP);
        step();
        rst = 1'b0;
        step();
        clk_ena = 1'b1; c0 = cyc;
        exp_tick(c0 + 104); exp_tick(c0 + 208); exp_tick(c0 + 312);
        samp(c0 + 1, K_DIV, M_EXP);
        wait_cyc(c0 + 314);

        // Get D=10 via a disabled cycle, then a mid-period load of 4
        div_in = 16'd10; div_load = 1'b1; step();
        div_load = 1'b0; clk_ena = 1'b0; step();
        samp(cyc, K_DIV, 10);
        clk_ena = 1'b1; c1 = cyc;
        exp_tick(c1 + 10); exp_tick(c1 + 20); exp_tick(c1 + 30);
        wait_cyc(c1 + 23);
        div_in = 16'd4; div_load = 1'b1; step();
        div_load = 1'b0;
        samp(c1 + 25, K_DIV, 10); samp(c1 + 29, K_DIV, 10); samp(c1 + 30, K_DIV, 4);
        exp_tick(c1 + 34); exp_tick(c1 + 38); exp_tick(c1 + 42); exp_tick(c1 + 46);

        // Clamp and overwrite: 0 then 1 before the wrap -> D=2
        wait_cyc(c1 + 43);
        div_in = 16'd0; div_load = 1'b1; step();
        div_in = 16'd1; step();
        div_load = 1'b0;
        samp(c1 + 45, K_DIV, 4); samp(c1 + 46, K_DIV, 2);
        exp_tick(c1 + 48); exp_tick(c1 + 50); exp_tick(c1 + 52); exp_tick(c1 + 54);

        // Load 3 on a wrap, then load 16 on a disabled cycle: 3 applied, 16 pending
        wait_cyc(c1 + 53);
        div_in = 16'd3; div_load = 1'b1; step();
        div_in = 16'd16; clk_ena = 1'b0; step();
        div_load = 1'b0; clk_ena = 1'b1;
        samp(cyc, K_DIV, 3); c2 = cyc;
        samp(c2 + 2, K_DIV, 3); samp(c2 + 3, K_DIV, 16);
        exp_tick(c2 + 3); exp_tick(c2 + 19); exp_tick(c2 + 35);
        exp_tick(c2 + 48); exp_tick(c2 + 64); exp_tick(c2 + 88); exp_tick(c2 + 104);
        // Restart mid-period at edge c2+40 -> tick at +8
        wait_cyc(c2 + 39);
        restart = 1'b1; step();
        restart = 1'b0;
        // Restart on the wrap edge c2+80 -> suppressed, next at c2+88
        wait_cyc(c2 + 79);
        restart = 1'b1; step();
        restart = 1'b0;

        // Square mode D=7, then D=8 applied at a wrap
        wait_cyc(c2 + 105);
        mode = 1'b1; div_in = 16'd7; div_load = 1'b1; step();
        div_load = 1'b0; clk_ena = 1'b0; step();
        clk_ena = 1'b1; c3 = cyc;
        samp(c3, K_CLKO, 0); samp(c3, K_DIV, 7);
        for (int k = 1; k <= 14; k++) samp(c3 + k, K_CLKO, sq7[k]);
        c4 = c3 + 21;
        exp_tick(c3 + 7); exp_tick(c3 + 14); exp_tick(c4);
        exp_tick(c4 + 8); exp_tick(c4 + 16); exp_tick(c4 + 24); exp_tick(c4 + 32);
        samp(c4 - 1, K_DIV, 7); samp(c4, K_DIV, 8);
        for (int k = 0; k <= 15; k++) samp(c4 + k, K_CLKO, sq8[k]);
        samp(c4 + 34, K_CLKO, 1);
        wait_cyc(c3 + 15);
        div_in = 16'd8; div_load = 1'b1; step();
        div_load = 1'b0;

        // Drop clk_ena one edge before a wrap: that tick is lost
        wait_cyc(c4 + 39);
        clk_ena = 1'b0; step();
        samp(cyc, K_CLKO, 0); samp(cyc, K_TICK, 0); samp(cyc, K_DIV, 8);
        step();
        clk_ena = 1'b1; c5 = cyc;
        exp_tick(c5 + 8); exp_tick(c5 + 16);
        samp(c5 + 1, K_CLKO, 1); samp(c5 + 17, K_CLKO, 1);

        // Async reset between edges with a load pending; pending load discarded
        wait_cyc(c5 + 17);
        div_in = 16'd5; div_load = 1'b1; step();
        div_load = 1'b0; rst = 1'b1;
        samp(cyc, K_TICK, 0); samp(cyc, K_CLKO, 0); samp(cyc, K_DIV, M_EXP);
        step();
        rst = 1'b0; c6 = cyc;
        exp_tick(c6 + 104); exp_tick(c6 + 208);
        wait_cyc(c6 + 212);

        check("leftover_ticks", tick_q.size(), 0);
        check("leftover_samples", samp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_baud_tick_gen
